// File: rtl/acc_rr_arbiter.sv
// ----------------------------------------------------------------------------
// acc_rr_arbiter
// Shares one accelerator Q/P bus pair between NumReq requesters.
//  - Q side: round-robin arbitration with the grant held while a request
//    is presented downstream but not yet accepted.
//  - P side: one-entry response register steered back by req_id; responses
//    whose req_id does not name a requester are dropped and flagged.
// ----------------------------------------------------------------------------
module acc_rr_arbiter #(
   parameter int unsigned NumReq       = 4,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AccAddrWidth = 5,
   parameter int unsigned IdWidth      = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   // requester-side Q channel
   input  logic [AccAddrWidth-1:0] slv_q_addr_i      [NumReq],
   input  logic [31:0]             slv_q_data_op_i   [NumReq],
   input  logic [DataWidth-1:0]    slv_q_data_arga_i [NumReq],
   input  logic [DataWidth-1:0]    slv_q_data_argb_i [NumReq],
   input  logic [DataWidth-1:0]    slv_q_data_argc_i [NumReq],
   input  logic [4:0]              slv_q_rd_id_i     [NumReq],
   input  logic [NumReq-1:0]       slv_q_valid_i,
   output logic [NumReq-1:0]       slv_q_ready_o,
   // requester-side P channel
   output logic [DataWidth-1:0]    slv_p_data_o      [NumReq],
   output logic [4:0]              slv_p_rd_id_o     [NumReq],
   output logic [NumReq-1:0]       slv_p_error_o,
   output logic [NumReq-1:0]       slv_p_valid_o,
   input  logic [NumReq-1:0]       slv_p_ready_i,
   // accelerator-side Q channel
   output logic [AccAddrWidth-1:0] mst_q_addr_o,
   output logic [31:0]             mst_q_data_op_o,
   output logic [DataWidth-1:0]    mst_q_data_arga_o,
   output logic [DataWidth-1:0]    mst_q_data_argb_o,
   output logic [DataWidth-1:0]    mst_q_data_argc_o,
   output logic [4:0]              mst_q_rd_id_o,
   output logic [IdWidth-1:0]      mst_q_req_id_o,
   output logic                    mst_q_valid_o,
   input  logic                    mst_q_ready_i,
   // accelerator-side P channel
   input  logic [DataWidth-1:0]    mst_p_data_i,
   input  logic [4:0]              mst_p_rd_id_i,
   input  logic                    mst_p_error_i,
   input  logic [IdWidth-1:0]      mst_p_req_id_i,
   input  logic                    mst_p_valid_i,
   output logic                    mst_p_ready_o,
   // dropped-response indication
   output logic                    route_err_o
);

   localparam int unsigned PtrW = $clog2(NumReq);

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_e;

   // Q-side state
   lock_state_e         r_state;
   logic [PtrW-1:0]     r_rr_ptr;
   logic [PtrW-1:0]     r_locked_idx;

   // Q-side combinational
   logic [PtrW-1:0]     w_hi_idx;
   logic [PtrW-1:0]     w_lo_idx;
   logic                w_hi_found;
   logic                w_lo_found;
   logic [PtrW-1:0]     w_rr_winner;
   logic [PtrW-1:0]     w_winner;
   logic [NumReq-1:0]   w_grant_oh;
   logic                w_q_valid;
   logic                w_q_hs;

   // P-side state
   logic                r_p_full;
   logic [PtrW-1:0]     r_p_id;
   logic [DataWidth-1:0] r_p_data;
   logic [4:0]          r_p_rd;
   logic                r_p_err;
   logic                r_route_err;

   // P-side combinational
   logic [NumReq-1:0]   w_p_oh;
   logic                w_buf_rdy;
   logic                w_p_acc;
   logic [31:0]         w_p_id_ext;
   logic                w_p_id_bad;

   // Round-robin search: first valid at or above the pointer, else first valid overall
   always_comb begin
      w_hi_idx   = {PtrW{1'b0}};
      w_lo_idx   = {PtrW{1'b0}};
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      for (int i = 0; i < int'(NumReq); i++) begin
         w_hi_idx   = (slv_q_valid_i[i] && (PtrW'(i) >= r_rr_ptr) && !w_hi_found) ? PtrW'(i) : w_hi_idx;
         w_hi_found = w_hi_found | (slv_q_valid_i[i] & (PtrW'(i) >= r_rr_ptr));
         w_lo_idx   = (slv_q_valid_i[i] && !w_lo_found) ? PtrW'(i) : w_lo_idx;
         w_lo_found = w_lo_found | slv_q_valid_i[i];
      end
      w_rr_winner = w_hi_found ? w_hi_idx : (w_lo_found ? w_lo_idx : r_rr_ptr);
      w_winner    = (r_state == ST_LOCKED) ? r_locked_idx : w_rr_winner;
   end

   // Steer the winner's request downstream through a one-hot AND-OR mux
   always_comb begin
      mst_q_addr_o      = {AccAddrWidth{1'b0}};
      mst_q_data_op_o   = 32'h0000_0000;
      mst_q_data_arga_o = {DataWidth{1'b0}};
      mst_q_data_argb_o = {DataWidth{1'b0}};
      mst_q_data_argc_o = {DataWidth{1'b0}};
      mst_q_rd_id_o     = 5'b00000;
      w_grant_oh        = {NumReq{1'b0}};
      for (int i = 0; i < int'(NumReq); i++) begin
         w_grant_oh[i]     = (w_winner == PtrW'(i));
         mst_q_addr_o      = mst_q_addr_o      | (slv_q_addr_i[i]      & {AccAddrWidth{w_grant_oh[i]}});
         mst_q_data_op_o   = mst_q_data_op_o   | (slv_q_data_op_i[i]   & {32{w_grant_oh[i]}});
         mst_q_data_arga_o = mst_q_data_arga_o | (slv_q_data_arga_i[i] & {DataWidth{w_grant_oh[i]}});
         mst_q_data_argb_o = mst_q_data_argb_o | (slv_q_data_argb_i[i] & {DataWidth{w_grant_oh[i]}});
         mst_q_data_argc_o = mst_q_data_argc_o | (slv_q_data_argc_i[i] & {DataWidth{w_grant_oh[i]}});
         mst_q_rd_id_o     = mst_q_rd_id_o     | (slv_q_rd_id_i[i]     & {5{w_grant_oh[i]}});
      end
      w_q_valid      = |(slv_q_valid_i & w_grant_oh);
      w_q_hs         = w_q_valid & mst_q_ready_i;
      mst_q_req_id_o = IdWidth'(w_winner);
      // Handshake outputs are forced idle while reset is asserted
      mst_q_valid_o  = w_q_valid & rst_ni;
      slv_q_ready_o  = w_grant_oh & {NumReq{mst_q_ready_i & rst_ni}};
   end

   // Lock FSM and round-robin pointer: hold the grant until the pending request is accepted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_UNLOCKED;
         r_locked_idx <= {PtrW{1'b0}};
         r_rr_ptr     <= {PtrW{1'b0}};
      end else begin
         if (w_q_hs) begin
            r_rr_ptr <= (w_winner == PtrW'(NumReq - 1)) ? {PtrW{1'b0}} : (w_winner + PtrW'(1'b1));
         end else begin
            r_rr_ptr <= r_rr_ptr;
         end
         case (r_state)
            ST_UNLOCKED: begin
               if (w_q_valid && !mst_q_ready_i) begin
                  r_state      <= ST_LOCKED;
                  r_locked_idx <= w_winner;
               end else begin
                  r_state <= ST_UNLOCKED;
               end
            end
            ST_LOCKED: begin
               // A requester dropping valid here does not release the lock
               if (w_q_hs) begin
                  r_state <= ST_UNLOCKED;
               end else begin
                  r_state <= ST_LOCKED;
               end
            end
            default: begin
               r_state <= ST_UNLOCKED;
            end
         endcase
      end
   end

   // Response routing: target select, accept condition and out-of-range id detection
   always_comb begin
      w_p_oh = {NumReq{1'b0}};
      for (int i = 0; i < int'(NumReq); i++) begin
         w_p_oh[i]        = (r_p_id == PtrW'(i));
         slv_p_data_o[i]  = r_p_data;
         slv_p_rd_id_o[i] = r_p_rd;
      end
      slv_p_error_o = {NumReq{r_p_err}};
      slv_p_valid_o = w_p_oh & {NumReq{r_p_full}};
      w_buf_rdy     = |(slv_p_ready_i & w_p_oh);
      mst_p_ready_o = ~r_p_full | w_buf_rdy;
      w_p_acc       = mst_p_valid_i & mst_p_ready_o;
      w_p_id_ext    = 32'(mst_p_req_id_i);
      w_p_id_bad    = (w_p_id_ext >= 32'(NumReq));
      route_err_o   = r_route_err;
   end

   // One-entry response register: capture, retire, and flag dropped responses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_p_full    <= 1'b0;
         r_p_id      <= {PtrW{1'b0}};
         r_p_data    <= {DataWidth{1'b0}};
         r_p_rd      <= 5'b00000;
         r_p_err     <= 1'b0;
         r_route_err <= 1'b0;
      end else begin
         r_route_err <= w_p_acc & w_p_id_bad;
         if (w_p_acc && !w_p_id_bad) begin
            // Covers back-to-back: a retiring entry is replaced in the same cycle
            r_p_full <= 1'b1;
            r_p_id   <= mst_p_req_id_i[PtrW-1:0];
            r_p_data <= mst_p_data_i;
            r_p_rd   <= mst_p_rd_id_i;
            r_p_err  <= mst_p_error_i;
         end else if (r_p_full && w_buf_rdy) begin
            r_p_full <= 1'b0;
         end else begin
            r_p_full <= r_p_full;
         end
      end
   end

endmodule
